// File: rtl/status_reg_if.sv
// Bus between the 6502 control/ALU side and the status register block.
interface status_reg_if;
    logic [7:0] alu_flag;
    logic       alu_we;
    logic [7:0] flag_mask;
    logic       sc_en;
    logic [2:0] sc_bit;
    logic       sc_val;
    logic       pull_en;
    logic [7:0] pull_data;
    logic       push_brk;
    logic [7:0] push_data;
    logic       irq_n;
    logic       nmi_n;
    logic       int_ack;
    logic       int_req;
    logic       int_nmi;
    logic [7:0] p;

    // core side: drives flag updates, stack traffic, pins and acknowledge
    modport master (
        output alu_flag, alu_we, flag_mask, sc_en, sc_bit, sc_val,
               pull_en, pull_data, push_brk, irq_n, nmi_n, int_ack,
        input  push_data, int_req, int_nmi, p
    );

    // status register side
    modport slave (
        input  alu_flag, alu_we, flag_mask, sc_en, sc_bit, sc_val,
               pull_en, pull_data, push_brk, irq_n, nmi_n, int_ack,
        output push_data, int_req, int_nmi, p
    );
endinterface

// File: rtl/status_reg.sv
// 6502 processor status register P with IRQ/NMI synchronisers and the
// interrupt request front end. Bit 5 always reads 1, bit 4 always reads 0.
module status_reg #(
    parameter logic [7:0] RESET_P     = 8'h24,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    status_reg_if.slave   bus
);
    localparam logic [7:0] RST_VAL = (RESET_P | 8'h20) & ~8'h10;

    logic [7:0]             p_q, p_nxt;
    logic [SYNC_STAGES-1:0] irq_sync, nmi_sync;
    logic                   irq_s, nmi_s, nmi_prev;
    logic                   nmi_fall, nmi_pend;
    logic                   irq_act;

    assign irq_s    = irq_sync[SYNC_STAGES-1];
    assign nmi_s    = nmi_sync[SYNC_STAGES-1];
    assign nmi_fall = nmi_prev & ~nmi_s;

    // Next P: pull beats set/clear beats ALU; acknowledge forces I on top.
    always_comb begin
        p_nxt = p_q;
        if (bus.pull_en) begin
            p_nxt = bus.pull_data;
        end else if (bus.sc_en) begin
            // B and the unused bit have no storage meaning, so ignore them
            if (bus.sc_bit != 3'd4 && bus.sc_bit != 3'd5)
                p_nxt[bus.sc_bit] = bus.sc_val;
        end else if (bus.alu_we) begin
            p_nxt = (bus.alu_flag & bus.flag_mask) | (p_q & ~bus.flag_mask);
        end
        if (bus.int_ack)
            p_nxt[2] = 1'b1;
        p_nxt[5] = 1'b1;
        p_nxt[4] = 1'b0;
    end

    // Status register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_q <= RST_VAL;
        else        p_q <= p_nxt;
    end

    // Pin synchronisers; nmi_prev holds the previous synced NMI level for
    // falling-edge detection. Reset to the inactive (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync <= '1;
            nmi_sync <= '1;
            nmi_prev <= 1'b1;
        end else begin
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], bus.irq_n};
            nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], bus.nmi_n};
            nmi_prev <= nmi_s;
        end
    end

    // NMI pending latch: a new edge wins over a same-cycle acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            nmi_pend <= 1'b0;
        else if (nmi_fall)     nmi_pend <= 1'b1;
        else if (bus.int_ack)  nmi_pend <= 1'b0;
    end

    // Outputs come straight from registered state; IRQ is an unlatched level.
    assign irq_act       = ~irq_s & ~p_q[2];
    assign bus.int_req   = nmi_pend | irq_act;
    assign bus.int_nmi   = nmi_pend;
    assign bus.p         = p_q;
    assign bus.push_data = {p_q[7:6], 1'b1, bus.push_brk, p_q[3:0]};
endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: directed scenarios plus random traffic
// against a byte-level reference model using pin-history queues.
module tb_status_reg;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    status_reg_if bus();

    status_reg #(.RESET_P(8'h24), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int nvec = 0;
    int nbad = 0;

    // reference model state
    logic [7:0] mp;
    logic       mpend;
    logic       ih[$];
    logic       nh[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %02h want %02h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mp    = 8'h24;
        mpend = 1'b0;
        ih.delete();
        nh.delete();
        for (int i = 0; i < SYNC + 2; i++) begin
            ih.push_back(1'b1);
            nh.push_back(1'b1);
        end
    endtask

    // One rising edge of the reference: ih[k]/nh[k] hold the pin value
    // sampled k+1 edges ago, so the synchronised level is entry SYNC-1.
    task automatic model_edge();
        logic       fall;
        logic [7:0] np;
        fall = nh[SYNC] & ~nh[SYNC-1];
        if (fall)              mpend = 1'b1;
        else if (bus.int_ack)  mpend = 1'b0;
        np = mp;
        if (bus.pull_en)
            np = bus.pull_data;
        else if (bus.sc_en) begin
            if (bus.sc_bit != 3'd4 && bus.sc_bit != 3'd5)
                np = bus.sc_val ? (mp | (8'd1 << bus.sc_bit)) : (mp & ~(8'd1 << bus.sc_bit));
        end else if (bus.alu_we)
            np = (mp & ~bus.flag_mask) | (bus.alu_flag & bus.flag_mask);
        if (bus.int_ack) np = np | 8'h04;
        mp = (np | 8'h20) & 8'hEF;
        ih.push_front(bus.irq_n); void'(ih.pop_back());
        nh.push_front(bus.nmi_n); void'(nh.pop_back());
    endtask

    task automatic check_model(input string tag);
        logic req;
        req = mpend | (~ih[SYNC-1] & ~mp[2]);
        chk({tag, ".p"},    bus.p, mp);
        chk({tag, ".push"}, bus.push_data, (mp & 8'hCF) | 8'h20 | (bus.push_brk ? 8'h10 : 8'h00));
        chk({tag, ".req"},  {7'd0, bus.int_req}, {7'd0, req});
        chk({tag, ".nmi"},  {7'd0, bus.int_nmi}, {7'd0, mpend});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic idle();
        bus.alu_flag = 8'h00; bus.alu_we = 1'b0; bus.flag_mask = 8'h00;
        bus.sc_en = 1'b0; bus.sc_bit = 3'd0; bus.sc_val = 1'b0;
        bus.pull_en = 1'b0; bus.pull_data = 8'h00; bus.push_brk = 1'b0;
        bus.int_ack = 1'b0;
    endtask

    // Asynchronous reset away from any edge; outputs must clear at once.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_p"},   bus.p, 8'h24);
        chk({tag, ".rst_req"}, {7'd0, bus.int_req}, 8'h00);
        chk({tag, ".rst_nmi"}, {7'd0, bus.int_nmi}, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        bus.irq_n = 1'b1;
        bus.nmi_n = 1'b1;
        rst_n = 1'b1;
        #2;
        do_reset("init");

        // ALU masked update
        bus.alu_we = 1'b1; bus.flag_mask = 8'h83; bus.alu_flag = 8'hC3;
        step("alu");
        chk("alu_a7", bus.p, 8'hA7);
        idle();

        // pull beats ALU, push image with/without B
        bus.pull_en = 1'b1; bus.pull_data = 8'hFF;
        bus.alu_we = 1'b1; bus.flag_mask = 8'hFF; bus.alu_flag = 8'h00;
        step("pull");
        chk("pull_ef", bus.p, 8'hEF);
        idle();
        bus.push_brk = 1'b1; #1;
        chk("push_b1", bus.push_data, 8'hFF);
        bus.push_brk = 1'b0; #1;
        chk("push_b0", bus.push_data, 8'hEF);

        // IRQ level path
        do_reset("r2");
        bus.sc_en = 1'b1; bus.sc_bit = 3'd2; bus.sc_val = 1'b0; bus.irq_n = 1'b0;
        step("cli");
        chk("cli_p", bus.p, 8'h20);
        idle();
        step("irq1");
        chk("irq_req", {7'd0, bus.int_req}, 8'h01);
        chk("irq_nmi", {7'd0, bus.int_nmi}, 8'h00);
        bus.int_ack = 1'b1;
        step("irq_ack");
        bus.int_ack = 1'b0;
        chk("ack_p", bus.p, 8'h24);
        chk("ack_req", {7'd0, bus.int_req}, 8'h00);
        step("irq_masked");
        bus.irq_n = 1'b1;

        // NMI edge path
        bus.nmi_n = 1'b0;
        step("nmi1");
        step("nmi2");
        chk("nmi_early", {7'd0, bus.int_req}, 8'h00);
        step("nmi3");
        chk("nmi_req", {7'd0, bus.int_req}, 8'h01);
        chk("nmi_nmi", {7'd0, bus.int_nmi}, 8'h01);
        bus.int_ack = 1'b1;
        step("nmi_ack");
        bus.int_ack = 1'b0;
        chk("nmi_clr", {7'd0, bus.int_nmi}, 8'h00);
        for (int i = 0; i < 4; i++) step("nmi_hold");
        chk("nmi_noretrig", {7'd0, bus.int_req}, 8'h00);
        bus.nmi_n = 1'b1;
        for (int i = 0; i < 3; i++) step("nmi_hi");
        bus.nmi_n = 1'b0;
        for (int i = 0; i < 3; i++) step("nmi_re");
        chk("nmi_reset", {7'd0, bus.int_nmi}, 8'h01);
        bus.int_ack = 1'b1;
        step("nmi_ack2");
        bus.int_ack = 1'b0;

        // edge detected in the acknowledge cycle keeps NMI pending
        bus.nmi_n = 1'b1;
        for (int i = 0; i < 3; i++) step("race_hi");
        bus.nmi_n = 1'b0;
        step("race1");
        step("race2");
        bus.int_ack = 1'b1;
        step("race_ack");
        bus.int_ack = 1'b0;
        chk("race_keep", {7'd0, bus.int_nmi}, 8'h01);

        // reset discards pending NMI
        #1;
        do_reset("r3");
        bus.nmi_n = 1'b1;
        step("post_rst");
        chk("rst_discard", {7'd0, bus.int_nmi}, 8'h00);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            bus.alu_we    = ($urandom_range(1, 0) == 1);
            bus.alu_flag  = 8'($urandom);
            bus.flag_mask = 8'($urandom);
            bus.sc_en     = ($urandom_range(3, 0) == 0);
            bus.sc_bit    = 3'($urandom);
            bus.sc_val    = 1'($urandom);
            bus.pull_en   = ($urandom_range(9, 0) == 0);
            bus.pull_data = 8'($urandom);
            bus.push_brk  = 1'($urandom);
            bus.int_ack   = ($urandom_range(7, 0) == 0);
            if ($urandom_range(7, 0) == 0) bus.irq_n = ~bus.irq_n;
            if ($urandom_range(5, 0) == 0) bus.nmi_n = ~bus.nmi_n;
            if ($urandom_range(499, 0) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step("rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
